// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter with start/busy/done handshake.
// Optional macro BIN2BCD_SATURATE_EN: out-of-range operands produce all-nines instead of the modulo result.
module bin_to_bcd_seq #(
    parameter int IN_W   = 14,
    parameter int DIGITS = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [IN_W-1:0]       i_bin,
    output logic [4*DIGITS-1:0]   o_bcd,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_ovf
);

    localparam int BCD_W   = 4 * DIGITS;
    localparam int CNT_W   = $clog2(IN_W + 1);
    localparam int MAX_VAL = (10 ** DIGITS) - 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IN_W-1:0]    opnd_q, opnd_d;
    logic [BCD_W-1:0]   scratch_q, scratch_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_flag_q, ovf_flag_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               ovf_q, ovf_d;

    logic [BCD_W-1:0]   adj;
    logic [BCD_W-1:0]   nines;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_nines
            assign nines[4*gi +: 4] = 4'd9;
        end
    endgenerate

    // Per-digit +3 correction; carries only propagate through the following shift.
    always_comb begin
        adj = scratch_q;
        for (int d = 0; d < DIGITS; d++) begin
            if (scratch_q[4*d +: 4] >= 4'd5) begin
                adj[4*d +: 4] = scratch_q[4*d +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        opnd_d     = opnd_q;
        scratch_d  = scratch_q;
        cnt_d      = cnt_q;
        ovf_flag_d = ovf_flag_q;
        bcd_d      = bcd_q;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        ovf_d      = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    opnd_d     = i_bin;
                    scratch_d  = '0;
                    cnt_d      = CNT_W'(IN_W);
                    ovf_flag_d = 32'(i_bin) > 32'(MAX_VAL);
                    busy_d     = 1'b1;
                    state_d    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                scratch_d = {adj[BCD_W-2:0], opnd_q[IN_W-1]};
                opnd_d    = {opnd_q[IN_W-2:0], 1'b0};
                cnt_d     = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    // Outputs are registered on entry to DONE so they coincide with that cycle.
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    ovf_d   = ovf_flag_q;
`ifdef BIN2BCD_SATURATE_EN
                    bcd_d   = ovf_flag_q ? nines : scratch_d;
`else
                    bcd_d   = scratch_d;
`endif
                end else begin
                    busy_d = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            opnd_q     <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            ovf_flag_q <= 1'b0;
            bcd_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            opnd_q     <= opnd_d;
            scratch_q  <= scratch_d;
            cnt_q      <= cnt_d;
            ovf_flag_q <= ovf_flag_d;
            bcd_q      <= bcd_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
        end
    end

`ifndef BIN2BCD_SATURATE_EN
    // The all-nines pattern is only consumed by the saturating build.
    logic unused_nines;
    assign unused_nines = ^nines;
`endif

    assign o_bcd  = bcd_q;
    assign o_busy = busy_q;
    assign o_done = done_q;
    assign o_ovf  = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: vector table, handshake corner cases, random vs reference model.
module tb_bin_to_bcd_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [13:0] bin;
    logic [15:0] bcd;
    logic        busy, done, ovf;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        logic [13:0] bin;
        logic [15:0] bcd;
        logic        ovf;
    } vec_t;

    vec_t vecs[7];

    bin_to_bcd_seq #(.IN_W(14), .DIGITS(4)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_start (start),
        .i_bin   (bin),
        .o_bcd   (bcd),
        .o_busy  (busy),
        .o_done  (done),
        .o_ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference: decimal digits extracted arithmetically from the operand.
    function automatic logic [15:0] ref_bcd(input int v);
        logic [15:0] r;
        int m;
`ifdef BIN2BCD_SATURATE_EN
        if (v > 9999) return 16'h9999;
`endif
        m = v % 10000;
        r = '0;
        for (int d = 0; d < 4; d++) begin
            r[4*d +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    // One-cycle start; returns result plus latency (cycles after the start edge) and busy count.
    task automatic convert(input logic [13:0] v, output logic [15:0] r_bcd, output logic r_ovf,
                           output int lat, output int busy_cnt);
        @(negedge clk);
        bin   = v;
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        lat      = 1;
        busy_cnt = 0;
        while (!done && lat < 40) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
        r_bcd = bcd;
        r_ovf = ovf;
    endtask

    initial begin
        logic [15:0] r_bcd;
        logic        r_ovf;
        int          lat, bcnt, ndone, gap;
        logic [15:0] held;

        vecs[0] = '{14'd1234,  16'h1234, 1'b0};
        vecs[1] = '{14'd0,     16'h0000, 1'b0};
        vecs[2] = '{14'd9999,  16'h9999, 1'b0};
        vecs[3] = '{14'd10,    16'h0010, 1'b0};
        vecs[4] = '{14'd9,     16'h0009, 1'b0};
`ifdef BIN2BCD_SATURATE_EN
        vecs[5] = '{14'd12345, 16'h9999, 1'b1};
        vecs[6] = '{14'd16383, 16'h9999, 1'b1};
`else
        vecs[5] = '{14'd12345, 16'h2345, 1'b1};
        vecs[6] = '{14'd16383, 16'h6383, 1'b1};
`endif

        rst_n = 1'b0;
        start = 1'b0;
        bin   = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("reset_bcd",  32'(bcd),  32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        check("reset_ovf",  32'(ovf),  32'h0);

        // Detailed timing of the first conversion.
        convert(14'd1234, r_bcd, r_ovf, lat, bcnt);
        check("t1234_latency", 32'(lat),  32'd15);
        check("t1234_busy_cycles", 32'(bcnt), 32'd14);
        check("t1234_busy_in_done", 32'(busy), 32'h0);
        @(negedge clk);
        check("t1234_done_pulse_len", 32'(done), 32'h0);
        repeat (3) @(negedge clk);
        check("t1234_hold", 32'(bcd), 32'h1234);

        foreach (vecs[i]) begin
            convert(vecs[i].bin, r_bcd, r_ovf, lat, bcnt);
            $display("vec %0d: bin=%0d bcd=0x%h ovf=%0d lat=%0d", i, vecs[i].bin, r_bcd, r_ovf, lat);
            check($sformatf("vec%0d_done", i), 32'(done),  32'h1);
            check($sformatf("vec%0d_bcd", i),  32'(r_bcd), 32'(vecs[i].bcd));
            check($sformatf("vec%0d_ovf", i),  32'(r_ovf), 32'(vecs[i].ovf));
        end

        // Start during SHIFT is ignored and a changed operand has no effect.
        @(negedge clk);
        bin   = 14'd1234;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        held  = '0;
        for (int j = 1; j <= 30; j++) begin
            if (j == 5) begin bin = 14'd5678; start = 1'b1; end
            if (j == 6) begin bin = 14'd777;  start = 1'b0; end
            if (done) begin ndone++; held = bcd; end
            @(negedge clk);
        end
        $display("ignore-start: done pulses=%0d bcd=0x%h", ndone, held);
        check("ignore_done_count", 32'(ndone), 32'd1);
        check("ignore_bcd", 32'(held), 32'h1234);
        convert(14'd5678, r_bcd, r_ovf, lat, bcnt);
        check("after_ignore_bcd", 32'(r_bcd), 32'h5678);

        // Reset in the middle of a conversion.
        @(negedge clk);
        bin   = 14'd4321;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        for (int j = 1; j <= 25; j++) begin
            if (j == 7) rst_n = 1'b0;
            if (j == 8) rst_n = 1'b1;
            if (done) ndone++;
            @(negedge clk);
        end
        $display("mid-reset: done pulses=%0d bcd=0x%h busy=%0d", ndone, bcd, busy);
        check("midrst_no_done", 32'(ndone), 32'd0);
        check("midrst_bcd", 32'(bcd),  32'h0);
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_ovf", 32'(ovf),  32'h0);
        convert(14'd42, r_bcd, r_ovf, lat, bcnt);
        check("post_rst_bcd", 32'(r_bcd), 32'h0042);
        check("post_rst_lat", 32'(lat), 32'd15);

        // Held start: back-to-back conversions, one per IN_W+2 cycles.
        @(negedge clk);
        bin   = 14'd777;
        start = 1'b1;
        lat   = 0;
        while (!done && lat < 40) begin @(negedge clk); lat++; end
        check("b2b_first_done", 32'(done), 32'h1);
        @(negedge clk);
        gap = 1;
        while (!done && gap < 40) begin @(negedge clk); gap++; end
        start = 1'b0;
        $display("back-to-back: gap=%0d bcd=0x%h", gap, bcd);
        check("b2b_period", 32'(gap), 32'd16);
        check("b2b_bcd", 32'(bcd), 32'h0777);
        repeat (20) @(negedge clk);

        for (int i = 0; i < 30; i++) begin
            logic [13:0] v;
            v = 14'($urandom_range(0, 16383));
            convert(v, r_bcd, r_ovf, lat, bcnt);
            $display("rand %0d: bin=%0d bcd=0x%h ovf=%0d", i, v, r_bcd, r_ovf);
            check("rand_bcd", 32'(r_bcd), 32'(ref_bcd(int'(v))));
            check("rand_ovf", 32'(r_ovf), 32'(int'(v) > 9999));
            check("rand_lat", 32'(lat), 32'd15);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Sequential double-dabble converter: binary magnitude in, packed BCD digits (thousands..ones) out.
- Sits directly upstream of the 7-segment display stage. Its registered BCD word is the 4-bit-per-digit field that the display stage slices per digit.
- One conversion at a time, with a start/busy/done handshake. Result is held stable between conversions so displays never flicker mid-conversion.

Parameters:
- IN_W, 14, width of binary input (14 bits covers 0..9999 plus out-of-range values up to 16383).
- DIGITS, 4, number of BCD digits produced. Output width is 4*DIGITS.

Ports:
- i_clk  input  1  system clock, rising-edge.
- i_rst_n  input  1  reset; synchronous, active-low.
- i_start  input  1  conversion request; sampled only in IDLE.
- i_bin  input  IN_W  unsigned binary operand; captured on accepted start.
- o_bcd  output  4*DIGITS  packed BCD result, registered. Digit d occupies bits [4d+3:4d]; d=0 is ones.
- o_busy  output  1  high while a conversion is in progress (SHIFT state).
- o_done  output  1  one-cycle pulse when o_bcd has just been updated.
- o_ovf  output  1  registered flag: last accepted operand exceeded 10^DIGITS-1.

Behaviour:
- Reset, when i_rst_n=0 at a clock edge:
  - State goes to IDLE.
  - o_bcd=0, o_busy=0, o_done=0, o_ovf=0.
  - Shift register and bit counter cleared.
  - Reset mid-conversion aborts it; no done pulse is issued.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - On i_start=1 at edge k: capture i_bin into the operand shift register and clear the BCD scratch (4*DIGITS bits).
  - Load bit counter = IN_W and compute the overflow compare (i_bin > 10^DIGITS-1) into an internal flag.
  - Go to SHIFT; o_busy=1 from cycle k+1.
- SHIFT, per cycle:
  - Every scratch digit >= 5 gets +3.
  - Then shift {scratch, operand} left by 1. The operand MSB enters scratch bit 0; the scratch MSB is discarded.
  - Decrement the counter. When it reaches 0 (after exactly IN_W shifts), go to DONE.
- DONE, one cycle:
  - o_bcd <= scratch, o_ovf <= internal flag, o_done=1, o_busy=0.
  - Next state IDLE.
- Latency: start at edge k → o_done high and new o_bcd visible in cycle k+IN_W+1 (15 cycles for defaults). Throughput: one conversion per IN_W+2 cycles.
- i_start while in SHIFT or DONE is ignored; no queuing. i_start held high continuously gives back-to-back conversions, re-sampled on return to IDLE.
- i_bin changes after capture do not affect the running conversion.
- o_bcd and o_ovf hold their values except at the DONE update.
- Arithmetic: the digit adjust is 4-bit, with no carry between digits except through the shift. Out-of-range operands yield value mod 10^DIGITS (upper digit discarded) unless the optional feature is enabled.
- Every o_bcd digit is always a legal BCD code 0..9.

Optional Feature:
- Macro BIN2BCD_SATURATE_EN.
- Defined: when the captured operand exceeds 10^DIGITS-1, the DONE update writes all digits = 9 (0x9999 for defaults) instead of the modulo result; o_ovf=1.
- Not defined: o_bcd = operand mod 10^DIGITS; o_ovf=1 still flags the condition.
- In-range behaviour and latency are identical either way.

Test Plan:
- Reset then idle 5 cycles → o_bcd=0x0000, o_busy=0, o_done=0, o_ovf=0.
- i_bin=1234, 1-cycle start at edge k:
  - o_busy=1 for cycles k+1..k+14.
  - o_done=1 only at k+15, with o_bcd=0x1234 and o_ovf=0.
  - o_bcd unchanged afterwards.
- Boundaries:
  - i_bin=0 → 0x0000.
  - i_bin=9999 → 0x9999, ovf=0.
  - i_bin=10 → 0x0010.
  - i_bin=9 → 0x0009.
- i_bin=12345:
  - Without macro → o_bcd=0x2345, o_ovf=1.
  - With BIN2BCD_SATURATE_EN → 0x9999, o_ovf=1.
  - i_bin=16383 without macro → 0x6383.
- Start 1234, then pulse start with i_bin=5678 at k+5 and change i_bin → result 0x1234, only one done pulse; a new start after done with 5678 → 0x5678.
- Start 4321, assert i_rst_n=0 at k+7 for one cycle → no done pulse, all outputs 0. A following start with 42 → 0x0042 after 15 cycles.
